// File: rtl/fir_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_decimator_if
// Description : Sample stream in / requantized stream out bundle for the
//               FIR decimator, plus its status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_decimator_if;
    logic signed [31:0] y_in;
    logic               y_valid;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic               sat_seen;
    logic               drop_pulse;
    logic        [7:0]  drop_cnt;

    modport master (
        output y_in, y_valid, s_ready,
        input  s_data, s_valid, sat_seen, drop_pulse, drop_cnt
    );

    modport slave (
        input  y_in, y_valid, s_ready,
        output s_data, s_valid, sat_seen, drop_pulse, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : fir_decimator
// Description : Keeps every DECIM-th valid sample, rounds/saturates it to
//               16 bits and buffers it in a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input wire             clk,
    input wire             reset_n,
    fir_decimator_if.slave bus
);
    localparam int c_PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_PW-1:0]  c_PHASE_LAST = c_PW'(DECIM - 1);
    localparam logic signed [32:0] c_MAX = 33'sd32767;
    localparam logic signed [32:0] c_MIN = -33'sd32768;

    logic        [c_PW-1:0] r_phase;
    logic                   w_keep;
    logic signed [32:0]     w_ext;
    logic signed [32:0]     w_rq;
    logic                   w_pos;
    logic                   w_neg;
    logic signed [15:0]     w_sat_val;

    logic signed [15:0]     r_s1_data;
    logic                   r_s1_push;
    logic                   r_s1_sat;

    logic        [15:0]     r_mem [DEPTH];
    logic        [c_AW-1:0] r_wr_ptr;
    logic        [c_AW-1:0] r_rd_ptr;
    logic        [c_CW-1:0] r_count;
    logic                   w_not_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;
    logic                   r_sat_seen;
    logic        [7:0]      r_drop_cnt;

    assign w_keep = bus.y_valid && (r_phase == '0);
    assign w_ext  = {bus.y_in[31], bus.y_in};

    // 33-bit sum so the rounding offset can never wrap a full-scale input
    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [32:0] c_HALF = 33'sd1 <<< (SHIFT - 1);
            assign w_rq = (w_ext + c_HALF) >>> SHIFT;
        end else begin : g_noround
            assign w_rq = w_ext;
        end
    endgenerate

    assign w_pos = (w_rq > c_MAX);
    assign w_neg = (w_rq < c_MIN);

    always_comb begin
        w_sat_val = w_rq[15:0];
        if (w_pos) begin
            w_sat_val = 16'sh7FFF;
        end else if (w_neg) begin
            w_sat_val = 16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase   <= '0;
            r_s1_data <= '0;
            r_s1_push <= 1'b0;
            r_s1_sat  <= 1'b0;
        end else begin
            if (bus.y_valid) begin
                r_phase <= (r_phase == c_PHASE_LAST) ? '0 : r_phase + c_PW'(1);
            end
            r_s1_push <= w_keep;
            if (w_keep) begin
                r_s1_data <= w_sat_val;
                r_s1_sat  <= w_pos | w_neg;
            end
        end
    end

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_CW'(DEPTH));
    assign w_pop       = w_not_empty && bus.s_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr        = r_s1_push && (!w_full || w_pop);
    assign w_drop      = r_s1_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_s1_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sat_seen <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_s1_push && r_s1_sat) begin
                r_sat_seen <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign bus.s_valid    = w_not_empty;
    assign bus.s_data     = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign bus.sat_seen   = r_sat_seen;
    assign bus.drop_pulse = w_drop;
    assign bus.drop_cnt   = r_drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decimator
// Description : Directed, table-driven bench for fir_decimator in three
//               configurations (DECIM 4, 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decimator;
    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;

    fir_decimator_if ifa ();
    fir_decimator_if ifb ();
    fir_decimator_if ifc ();

    fir_decimator #(.DECIM(4), .SHIFT(4), .DEPTH(4)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    fir_decimator #(.DECIM(1), .SHIFT(4), .DEPTH(4)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));
    fir_decimator #(.DECIM(3), .SHIFT(4), .DEPTH(4)) u_dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));

    typedef struct {
        logic signed [31:0] y;
        logic signed [15:0] exp;
        logic               sat;
    } vec_t;

    localparam int c_NV = 14;
    vec_t vecs [c_NV];
    logic sat_exp [c_NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.y_valid = 1'b0; ifa.y_in = '0; ifa.s_ready = 1'b0;
        ifb.y_valid = 1'b0; ifb.y_in = '0; ifb.s_ready = 1'b0;
        ifc.y_valid = 1'b0; ifc.y_in = '0; ifc.s_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        chk("rst_valid_a", 32'(ifa.s_valid), 32'(0));
        chk("rst_data_b",  32'(ifb.s_data),  32'(0));
        chk("rst_sat_b",   32'(ifb.sat_seen), 32'(0));
        chk("rst_drop_c",  32'(ifc.drop_cnt), 32'(0));
        chk("rst_dpulse_b", 32'(ifb.drop_pulse), 32'(0));
        reset_n = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        idle_all();

        vecs[0]  = '{32'sd8,          16'sd1,      1'b0};
        vecs[1]  = '{-32'sd8,         16'sd0,      1'b0};
        vecs[2]  = '{-32'sd9,         -16'sd1,     1'b0};
        vecs[3]  = '{32'sd23,         16'sd1,      1'b0};
        vecs[4]  = '{32'sd24,         16'sd2,      1'b0};
        vecs[5]  = '{-32'sd24,        -16'sd1,     1'b0};
        vecs[6]  = '{-32'sd25,        -16'sd2,     1'b0};
        vecs[7]  = '{32'sd524279,     16'sd32767,  1'b0};
        vecs[8]  = '{-32'sd524296,    -16'sd32768, 1'b0};
        vecs[9]  = '{32'sd600000,     16'sd32767,  1'b1};
        vecs[10] = '{-32'sd600000,    -16'sd32768, 1'b1};
        vecs[11] = '{32'sd524280,     16'sd32767,  1'b1};
        vecs[12] = '{32'sh7FFFFFFF,   16'sd32767,  1'b1};
        vecs[13] = '{32'sh80000000,   -16'sd32768, 1'b1};
        for (int i = 0; i < c_NV; i++) begin
            sat_exp[i] = vecs[i].sat | ((i > 0) ? sat_exp[i-1] : 1'b0);
        end

        // Decimation by 4 with continuous input
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ifa.y_valid = 1'b1; ifa.y_in = 32'(16 * (k + 1)); ifa.s_ready = 1'b1;
            #1;
            chk("dec4_valid", 32'(ifa.s_valid), 32'(k >= 2 && (k - 2) % 4 == 0));
            if (k >= 2 && (k - 2) % 4 == 0) begin
                chk("dec4_data", 32'(ifa.s_data), 32'(1 + 4 * ((k - 2) / 4)));
            end
            tick();
        end

        // Rounding / saturation table at DECIM=1
        do_reset();
        for (int k = 0; k < c_NV + 2; k++) begin
            ifb.s_ready = 1'b1;
            if (k < c_NV) begin
                ifb.y_valid = 1'b1; ifb.y_in = vecs[k].y;
            end else begin
                ifb.y_valid = 1'b0; ifb.y_in = '0;
            end
            #1;
            if (k >= 2) begin
                chk("rq_valid", 32'(ifb.s_valid), 32'(1));
                chk("rq_data",  32'(ifb.s_data),  32'(vecs[k-2].exp));
                chk("rq_sat",   32'(ifb.sat_seen), 32'(sat_exp[k-2]));
            end else begin
                chk("rq_lat_valid", 32'(ifb.s_valid), 32'(0));
                chk("rq_lat_sat",   32'(ifb.sat_seen), 32'(0));
            end
            tick();
        end

        // Backpressure: 6 samples into a 4-deep FIFO
        do_reset();
        for (int c = 0; c < 8; c++) begin
            ifb.y_valid = (c < 6); ifb.y_in = 32'(16 * (c + 1)); ifb.s_ready = 1'b0;
            #1;
            chk("bp_drop_pulse", 32'(ifb.drop_pulse), 32'(c == 5 || c == 6));
            chk("bp_valid", 32'(ifb.s_valid), 32'(c >= 2));
            if (c >= 2) begin
                chk("bp_stable", 32'(ifb.s_data), 32'(1));
            end
            tick();
        end
        chk("bp_drop_cnt", 32'(ifb.drop_cnt), 32'(2));
        for (int d = 0; d < 5; d++) begin
            ifb.y_valid = 1'b0; ifb.s_ready = 1'b1;
            #1;
            chk("bp_drain_valid", 32'(ifb.s_valid), 32'(d < 4));
            if (d < 4) begin
                chk("bp_drain_data", 32'(ifb.s_data), 32'(d + 1));
            end
            tick();
        end

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int c = 0; c < 13; c++) begin
            ifb.y_valid = (c < 12); ifb.y_in = 32'(16 * (c + 1)); ifb.s_ready = (c >= 5);
            #1;
            chk("fp_no_drop", 32'(ifb.drop_pulse), 32'(0));
            if (c >= 5) begin
                chk("fp_valid", 32'(ifb.s_valid), 32'(1));
                chk("fp_data",  32'(ifb.s_data),  32'(c - 4));
            end
            tick();
        end
        ifb.y_valid = 1'b1; ifb.y_in = 32'(16 * 13); ifb.s_ready = 1'b0;
        #1;
        chk("fp_hold_nodrop", 32'(ifb.drop_pulse), 32'(0));
        tick();
        ifb.y_valid = 1'b0; ifb.s_ready = 1'b0;
        #1;
        chk("fp_still_full_drop", 32'(ifb.drop_pulse), 32'(1));
        chk("fp_head", 32'(ifb.s_data), 32'(9));
        tick();
        chk("fp_drop_cnt", 32'(ifb.drop_cnt), 32'(1));
        for (int d = 0; d < 5; d++) begin
            ifb.s_ready = 1'b1;
            #1;
            chk("fp_drain_valid", 32'(ifb.s_valid), 32'(d < 4));
            if (d < 4) begin
                chk("fp_drain_data", 32'(ifb.s_data), 32'(9 + d));
            end
            tick();
        end

        // Gapped input at DECIM=3; invalid cycles carry out-of-range junk
        do_reset();
        for (int c = 0; c < 24; c++) begin
            ifc.s_ready = 1'b1;
            ifc.y_valid = (c % 2 == 0);
            ifc.y_in = (c % 2 == 0) ? 32'(16 * (c / 2 + 1)) : 32'h7FFF0000;
            #1;
            chk("gap_valid", 32'(ifc.s_valid), 32'(c >= 2 && (c - 2) % 6 == 0));
            if (c >= 2 && (c - 2) % 6 == 0) begin
                chk("gap_data", 32'(ifc.s_data), 32'(1 + 3 * ((c - 2) / 6)));
            end
            tick();
        end
        chk("gap_no_sat", 32'(ifc.sat_seen), 32'(0));

        // Asynchronous reset with three entries buffered
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ifb.s_ready = 1'b0;
            ifb.y_valid = (c < 3);
            ifb.y_in = (c == 0) ? 32'sd600000 : 32'(16 * c);
            tick();
        end
        chk("mr_pre_valid", 32'(ifb.s_valid), 32'(1));
        chk("mr_pre_sat",   32'(ifb.sat_seen), 32'(1));
        chk("mr_pre_data",  32'(ifb.s_data), 32'(16'sh7FFF));
        ifb.y_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(ifb.s_valid), 32'(0));
        chk("mr_async_sat",   32'(ifb.sat_seen), 32'(0));
        chk("mr_async_drop",  32'(ifb.drop_cnt), 32'(0));
        chk("mr_async_data",  32'(ifb.s_data), 32'(0));
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ifb.s_ready = 1'b1; ifb.y_valid = (c == 0); ifb.y_in = 32'sd48;
            #1;
            chk("mr_first_valid", 32'(ifb.s_valid), 32'(c == 2));
            if (c == 2) begin
                chk("mr_first_data", 32'(ifb.s_data), 32'(3));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
